// File: rtl/uno_card_pkg.sv
// Shared types and constants for the UNO card sprite renderer.
package uno_card_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        BLUE   = 2'b10,
        GREEN  = 2'b11
    } card_color_e;

    typedef enum logic [1:0] {
        SCALE_1X     = 2'b00,
        SCALE_2X     = 2'b01,
        SCALE_4X     = 2'b10,
        SCALE_4X_ALT = 2'b11
    } card_scale_e;

    localparam logic [3:0] G_ZERO  = 4'd0;
    localparam logic [3:0] G_ONE   = 4'd1;
    localparam logic [3:0] G_TWO   = 4'd2;
    localparam logic [3:0] G_THREE = 4'd3;
    localparam logic [3:0] G_FOUR  = 4'd4;
    localparam logic [3:0] G_FIVE  = 4'd5;
    localparam logic [3:0] G_SIX   = 4'd6;
    localparam logic [3:0] G_SEVEN = 4'd7;
    localparam logic [3:0] G_EIGHT = 4'd8;
    localparam logic [3:0] G_NINE  = 4'd9;
    localparam logic [3:0] G_SKIP  = 4'd10;
    localparam logic [3:0] G_REV   = 4'd11;
    localparam logic [3:0] G_DRAW2 = 4'd12;
    localparam logic [3:0] G_WILD  = 4'd13;
    localparam logic [3:0] G_DRAW4 = 4'd14;
    localparam logic [3:0] G_BACK  = 4'd15;

    localparam int unsigned DEF_X_WIDTH = 30;
    localparam int unsigned DEF_Y_WIDTH = 50;

    // Scale code to left-shift amount; 11 behaves like 4x.
    function automatic logic [1:0] scale_shift(input logic [1:0] scale);
        case (scale)
            SCALE_1X: return 2'd0;
            SCALE_2X: return 2'd1;
            default:  return 2'd2;
        endcase
    endfunction

    // 3x5 centre symbol per glyph, row-major, MSB = top-left; 1 = ink stroke.
    function automatic logic [14:0] glyph_font(input logic [3:0] g);
        case (g)
            G_ZERO:  return 15'b111_101_101_101_111;
            G_ONE:   return 15'b010_110_010_010_111;
            G_TWO:   return 15'b111_001_111_100_111;
            G_THREE: return 15'b111_001_111_001_111;
            G_FOUR:  return 15'b101_101_111_001_001;
            G_FIVE:  return 15'b111_100_111_001_111;
            G_SIX:   return 15'b111_100_111_101_111;
            G_SEVEN: return 15'b111_001_010_010_010;
            G_EIGHT: return 15'b111_101_111_101_111;
            G_NINE:  return 15'b111_101_111_001_111;
            G_SKIP:  return 15'b011_100_010_001_110;
            G_REV:   return 15'b110_101_110_101_101;
            G_DRAW2: return 15'b010_111_010_000_111;
            G_WILD:  return 15'b101_101_101_111_101;
            G_DRAW4: return 15'b010_111_010_101_111;
            default: return 15'b111_111_111_111_111;
        endcase
    endfunction

endpackage

// File: rtl/card_glyph_rom.sv
// Synchronous 1-bit glyph ROM: bit = bitmap[glyph][v][u], one-cycle read latency.
// Bit 0 is ink (suit colour), bit 1 is white card face.
module card_glyph_rom
    import uno_card_pkg::*;
#(
    parameter int unsigned NUM_GLYPHS = 16,
    parameter int unsigned X_WIDTH    = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH    = DEF_Y_WIDTH
) (
    input  logic        clk,
    input  logic [3:0]  i_glyph,
    input  logic [10:0] i_u,
    input  logic [10:0] i_v,
    output logic        o_bit
);

    localparam int unsigned BOX_W = 12;
    localparam int unsigned BOX_H = 20;
    localparam int unsigned BOX_X0 = (X_WIDTH - BOX_W) / 2;
    localparam int unsigned BOX_Y0 = (Y_WIDTH - BOX_H) / 2;

    logic [3:0]  w_glyph;
    logic        w_edge_u;
    logic        w_edge_v;
    logic        w_in_box;
    logic [1:0]  w_col;
    logic [2:0]  w_row;
    logic [3:0]  w_idx;
    logic [14:0] w_font;
    logic        w_bit;

    // Bitmap generator: white rounded corners, ink ring, centred 4x-blown symbol.
    always_comb begin
        w_glyph  = (32'(i_glyph) >= NUM_GLYPHS) ? G_BACK : i_glyph;
        w_font   = glyph_font(w_glyph);
        w_edge_u = (i_u < 11'd2) || (i_u >= 11'(X_WIDTH - 2));
        w_edge_v = (i_v < 11'd2) || (i_v >= 11'(Y_WIDTH - 2));
        w_in_box = (i_u >= 11'(BOX_X0)) && (i_u < 11'(BOX_X0 + BOX_W)) &&
                   (i_v >= 11'(BOX_Y0)) && (i_v < 11'(BOX_Y0 + BOX_H));
        w_col    = 2'((i_u - 11'(BOX_X0)) >> 2);
        w_row    = 3'((i_v - 11'(BOX_Y0)) >> 2);
        w_idx    = 4'd14 - ((4'd3 * 4'(w_row)) + 4'(w_col));
        w_bit    = 1'b1;
        if (w_edge_u && w_edge_v) begin
            w_bit = 1'b1;
        end else if (w_edge_u || w_edge_v) begin
            w_bit = 1'b0;
        end else if (w_in_box) begin
            w_bit = ~w_font[w_idx];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        o_bit <= w_bit;
    end

endmodule

// File: rtl/uno_card_renderer.sv
// Three-stage UNO card sprite renderer with frame-synchronous attribute shadows
// and a blinking highlight border.
module uno_card_renderer
    import uno_card_pkg::*;
#(
    parameter int unsigned X_WIDTH      = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH      = DEF_Y_WIDTH,
    parameter int unsigned NUM_GLYPHS   = 16,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_start,
    input  logic       i_pix_valid,
    input  logic [9:0] i_x_cnt,
    input  logic [9:0] i_y_cnt,
    input  logic [9:0] i_x_pin,
    input  logic [9:0] i_y_pin,
    input  logic [3:0] i_glyph,
    input  logic [1:0] i_color,
    input  logic [1:0] i_scale,
    input  logic       i_highlight,
    output logic [7:0] o_r_data,
    output logic [7:0] o_g_data,
    output logic [7:0] o_b_data,
    output logic       o_hit,
    output logic       o_out_valid
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Shadow attributes and blink state
    logic [9:0]  r_x_pin, r_y_pin, w_x_pin, w_y_pin;
    logic [3:0]  r_glyph, w_glyph;
    card_color_e r_color, w_color;
    logic [1:0]  r_scale, w_scale;
    logic        r_hl, w_hl;
    logic [CNT_W-1:0] r_frame_cnt, w_cnt_nx;
    logic        r_blink_on, w_blink_nx;

    // Stage 1 signals
    logic [1:0]  w_shift;
    logic [10:0] w_x_ext, w_y_ext, w_xp_ext, w_yp_ext, w_x_end, w_y_end;
    logic [10:0] w_u, w_v;
    logic        w_inside, w_border, w_dark;
    logic        r1_valid, r1_inside, r1_dark;
    logic [10:0] r1_u, r1_v;
    logic [3:0]  r1_glyph;
    card_color_e r1_color;

    // Stage 2/3 signals
    logic        w_bit;
    logic        r2_valid, r2_inside, r2_dark;
    card_color_e r2_color;
    logic [7:0]  w_p, w_r, w_g, w_b;
    logic        w_hit;

    // Effective attributes: a frame_start pixel already sees the new values.
    always_comb begin
        w_x_pin    = i_frame_start ? i_x_pin : r_x_pin;
        w_y_pin    = i_frame_start ? i_y_pin : r_y_pin;
        w_glyph    = i_frame_start ? i_glyph : r_glyph;
        w_color    = i_frame_start ? card_color_e'(i_color) : r_color;
        w_scale    = i_frame_start ? i_scale : r_scale;
        w_hl       = i_frame_start ? i_highlight : r_hl;
        w_cnt_nx   = r_frame_cnt;
        w_blink_nx = r_blink_on;
        if (!w_hl) begin
            w_cnt_nx   = '0;
            w_blink_nx = 1'b0;
        end else if (i_frame_start && r_hl) begin
            if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                w_cnt_nx   = '0;
                w_blink_nx = ~r_blink_on;
            end else begin
                w_cnt_nx = r_frame_cnt + CNT_W'(1);
            end
        end
    end

    // Shadow and blink registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_pin     <= '0;
            r_y_pin     <= '0;
            r_glyph     <= '0;
            r_color     <= RED;
            r_scale     <= '0;
            r_hl        <= 1'b0;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else begin
            r_x_pin     <= w_x_pin;
            r_y_pin     <= w_y_pin;
            r_glyph     <= w_glyph;
            r_color     <= w_color;
            r_scale     <= w_scale;
            r_hl        <= w_hl;
            r_frame_cnt <= w_cnt_nx;
            r_blink_on  <= w_blink_nx;
        end
    end

    // Stage 1: half-open bounds in 11 bits, scaled sprite coordinates, border flag
    always_comb begin
        w_shift  = scale_shift(w_scale);
        w_x_ext  = 11'(i_x_cnt);
        w_y_ext  = 11'(i_y_cnt);
        w_xp_ext = 11'(w_x_pin);
        w_yp_ext = 11'(w_y_pin);
        w_x_end  = w_xp_ext + (11'(X_WIDTH) << w_shift);
        w_y_end  = w_yp_ext + (11'(Y_WIDTH) << w_shift);
        w_inside = (w_x_ext >= w_xp_ext) && (w_x_ext < w_x_end) &&
                   (w_y_ext >= w_yp_ext) && (w_y_ext < w_y_end);
        w_u      = (w_x_ext - w_xp_ext) >> w_shift;
        w_v      = (w_y_ext - w_yp_ext) >> w_shift;
        w_border = (w_u < 11'd2) || (w_u >= 11'(X_WIDTH - 2)) ||
                   (w_v < 11'd2) || (w_v >= 11'(Y_WIDTH - 2));
        w_dark   = w_hl && w_blink_nx && w_border;
    end

    // Stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_inside <= 1'b0;
            r1_dark   <= 1'b0;
            r1_u      <= '0;
            r1_v      <= '0;
            r1_glyph  <= '0;
            r1_color  <= RED;
        end else begin
            r1_valid  <= i_pix_valid;
            r1_inside <= w_inside;
            r1_dark   <= w_dark;
            r1_u      <= w_u;
            r1_v      <= w_v;
            r1_glyph  <= w_glyph;
            r1_color  <= w_color;
        end
    end

    card_glyph_rom #(
        .NUM_GLYPHS (NUM_GLYPHS),
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH)
    ) u_rom (
        .clk     (clk),
        .i_glyph (r1_glyph),
        .i_u     (r1_u),
        .i_v     (r1_v),
        .o_bit   (w_bit)
    );

    // Stage 2: flags travel alongside the ROM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid  <= 1'b0;
            r2_inside <= 1'b0;
            r2_dark   <= 1'b0;
            r2_color  <= RED;
        end else begin
            r2_valid  <= r1_valid;
            r2_inside <= r1_inside;
            r2_dark   <= r1_dark;
            r2_color  <= r1_color;
        end
    end

    // Stage 3: suit colouring, blink blackout, outside/invalid masking
    always_comb begin
        w_p   = {8{w_bit}};
        w_hit = r2_valid && r2_inside;
        w_r   = 8'h00;
        w_g   = 8'h00;
        w_b   = 8'h00;
        case (r2_color)
            RED:     begin w_r = 8'hFF; w_g = w_p;   w_b = w_p;   end
            YELLOW:  begin w_r = 8'hFF; w_g = 8'hFF; w_b = w_p;   end
            BLUE:    begin w_r = w_p;   w_g = w_p;   w_b = 8'hFF; end
            default: begin w_r = w_p;   w_g = 8'hFF; w_b = w_p;   end
        endcase
        if (!w_hit || r2_dark) begin
            w_r = 8'h00;
            w_g = 8'h00;
            w_b = 8'h00;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_r_data    <= '0;
            o_g_data    <= '0;
            o_b_data    <= '0;
            o_hit       <= 1'b0;
            o_out_valid <= 1'b0;
        end else begin
            o_r_data    <= w_r;
            o_g_data    <= w_g;
            o_b_data    <= w_b;
            o_hit       <= w_hit;
            o_out_valid <= r2_valid;
        end
    end

endmodule

// File: tb/tb_uno_card_renderer.sv
// Directed-vector bench for uno_card_renderer (BLINK_FRAMES overridden to 2).
module tb_uno_card_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_frame_start = 1'b0;
    logic       i_pix_valid = 1'b0;
    logic [9:0] i_x_cnt = '0, i_y_cnt = '0, i_x_pin = '0, i_y_pin = '0;
    logic [3:0] i_glyph = '0;
    logic [1:0] i_color = '0, i_scale = '0;
    logic       i_highlight = 1'b0;
    logic [7:0] o_r_data, o_g_data, o_b_data;
    logic       o_hit, o_out_valid;

    int total = 0;
    int bad = 0;

    uno_card_renderer #(
        .X_WIDTH(30), .Y_WIDTH(50), .NUM_GLYPHS(16), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .i_frame_start(i_frame_start), .i_pix_valid(i_pix_valid),
        .i_x_cnt(i_x_cnt), .i_y_cnt(i_y_cnt),
        .i_x_pin(i_x_pin), .i_y_pin(i_y_pin),
        .i_glyph(i_glyph), .i_color(i_color), .i_scale(i_scale),
        .i_highlight(i_highlight),
        .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data),
        .o_hit(o_hit), .o_out_valid(o_out_valid)
    );

    always #5 clk = ~clk;

    task automatic set_card(input logic [9:0] xp, input logic [9:0] yp, input logic [3:0] g,
                            input logic [1:0] c, input logic [1:0] s, input logic hl);
        i_x_pin = xp; i_y_pin = yp; i_glyph = g; i_color = c; i_scale = s; i_highlight = hl;
    endtask

    task automatic frame_pulse();
        i_frame_start = 1'b1;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
    endtask

    // Push one pixel, then sample the output 3 clocks after it was captured.
    task automatic render_px(input logic [9:0] x, input logic [9:0] y, input logic pv,
                             input logic fs, output logic [23:0] rgb, output logic h,
                             output logic ov);
        i_x_cnt = x; i_y_cnt = y; i_pix_valid = pv; i_frame_start = fs;
        @(posedge clk); #1;
        i_pix_valid = 1'b0; i_frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rgb = {o_r_data, o_g_data, o_b_data};
        h = o_hit;
        ov = o_out_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_r_data, o_g_data, o_b_data, o_hit, o_out_valid} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rgb=%h%h%h hit=%b vld=%b want all 0",
                     o_r_data, o_g_data, o_b_data, o_hit, o_out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [9:0]  xs [5] = '{10'd100, 10'd100, 10'd105, 10'd109, 10'd113};
        logic [9:0]  ys [5] = '{10'd53,  10'd50,  10'd55,  10'd65,  10'd69};
        logic [23:0] ex [5] = '{24'hFF0000, 24'hFFFFFF, 24'hFFFFFF, 24'hFF0000, 24'hFFFFFF};
        logic [23:0] rgb; logic h, ov;
        set_card(10'd100, 10'd50, 4'd0, 2'b00, 2'b00, 1'b0);
        frame_pulse();
        for (int i = 0; i < 5; i++) begin
            render_px(xs[i], ys[i], 1'b1, 1'b0, rgb, h, ov);
            total++;
            if (rgb !== ex[i] || h !== 1'b1 || ov !== 1'b1) begin
                bad++;
                $display("FAIL basic[%0d] (%0d,%0d): got rgb=%h hit=%b vld=%b want rgb=%h hit=1 vld=1",
                         i, xs[i], ys[i], rgb, h, ov, ex[i]);
            end
        end
    endtask

    task automatic test_bounds();
        logic [9:0]  xs [4] = '{10'd130, 10'd129, 10'd99, 10'd100};
        logic [9:0]  ys [4] = '{10'd50,  10'd99,  10'd60, 10'd100};
        logic        eh [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [23:0] ex [4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
        logic [23:0] rgb; logic h, ov;
        for (int i = 0; i < 4; i++) begin
            render_px(xs[i], ys[i], 1'b1, 1'b0, rgb, h, ov);
            total++;
            if (rgb !== ex[i] || h !== eh[i] || ov !== 1'b1) begin
                bad++;
                $display("FAIL bounds[%0d] (%0d,%0d): got rgb=%h hit=%b vld=%b want rgb=%h hit=%b vld=1",
                         i, xs[i], ys[i], rgb, h, ov, ex[i], eh[i]);
            end
        end
    endtask

    task automatic test_scale();
        logic [9:0]  xs [12] = '{10'd59, 10'd60, 10'd0, 10'd1, 10'd18, 10'd19, 10'd10, 10'd11, 10'd0,
                                 10'd119, 10'd120, 10'd36};
        logic [9:0]  ys [12] = '{10'd99, 10'd0, 10'd6, 10'd7, 10'd30, 10'd31, 10'd10, 10'd11, 10'd100,
                                 10'd199, 10'd0, 10'd60};
        logic [1:0]  sc [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                 2'b11, 2'b11, 2'b11};
        logic        eh [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b1};
        logic [23:0] ex [12] = '{24'hFFFFFF, 24'h0, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000,
                                 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFF0000};
        logic [23:0] rgb; logic h, ov;
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || i == 9) begin
                set_card(10'd0, 10'd0, 4'd0, 2'b00, sc[i], 1'b0);
                frame_pulse();
            end
            render_px(xs[i], ys[i], 1'b1, 1'b0, rgb, h, ov);
            total++;
            if (rgb !== ex[i] || h !== eh[i]) begin
                bad++;
                $display("FAIL scale[%0d] s=%b (%0d,%0d): got rgb=%h hit=%b want rgb=%h hit=%b",
                         i, sc[i], xs[i], ys[i], rgb, h, ex[i], eh[i]);
            end
        end
        // Card near the right edge must not wrap back to column 0.
        set_card(10'd1000, 10'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        frame_pulse();
        render_px(10'd1023, 10'd10, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFFFFFF || h !== 1'b1) begin
            bad++;
            $display("FAIL edge_inside: got rgb=%h hit=%b want rgb=ffffff hit=1", rgb, h);
        end
        render_px(10'd5, 10'd10, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'h000000 || h !== 1'b0) begin
            bad++;
            $display("FAIL edge_nowrap: got rgb=%h hit=%b want rgb=000000 hit=0", rgb, h);
        end
    endtask

    task automatic test_colors();
        logic [23:0] ex [4] = '{24'hFF0000, 24'hFFFF00, 24'h0000FF, 24'h00FF00};
        logic [23:0] rgb; logic h, ov;
        for (int c = 1; c < 4; c++) begin
            set_card(10'd100, 10'd50, 4'd0, 2'(c), 2'b00, 1'b0);
            frame_pulse();
            render_px(10'd100, 10'd53, 1'b1, 1'b0, rgb, h, ov);
            total++;
            if (rgb !== ex[c] || h !== 1'b1) begin
                bad++;
                $display("FAIL color_ink c=%0d: got rgb=%h hit=%b want rgb=%h hit=1", c, rgb, h, ex[c]);
            end
        end
        render_px(10'd100, 10'd50, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL color_white_green: got rgb=%h want rgb=ffffff", rgb);
        end
    endtask

    task automatic test_glyphs();
        logic [23:0] rgb; logic h, ov;
        set_card(10'd100, 10'd50, 4'd1, 2'b00, 2'b00, 1'b0);
        frame_pulse();
        render_px(10'd109, 10'd65, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL glyph1_gap: got rgb=%h want rgb=ffffff", rgb);
        end
        set_card(10'd100, 10'd50, 4'd15, 2'b00, 2'b00, 1'b0);
        frame_pulse();
        render_px(10'd113, 10'd69, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFF0000) begin
            bad++;
            $display("FAIL back_solid: got rgb=%h want rgb=ff0000", rgb);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  xs [5] = '{10'd100, 10'd100, 10'd130, 10'd105, 10'd100};
        logic [9:0]  ys [5] = '{10'd53,  10'd50,  10'd50,  10'd55,  10'd53};
        logic        pv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [23:0] ex [5] = '{24'hFF0000, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0};
        logic        eh [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        set_card(10'd100, 10'd50, 4'd0, 2'b00, 2'b00, 1'b0);
        frame_pulse();
        for (int i = 0; i < 8; i++) begin
            if (i >= 3) begin
                total++;
                if ({o_r_data, o_g_data, o_b_data} !== ex[i-3] || o_hit !== eh[i-3] ||
                    o_out_valid !== pv[i-3]) begin
                    bad++;
                    $display("FAIL b2b[%0d]: got rgb=%h%h%h hit=%b vld=%b want rgb=%h hit=%b vld=%b",
                             i - 3, o_r_data, o_g_data, o_b_data, o_hit, o_out_valid,
                             ex[i-3], eh[i-3], pv[i-3]);
                end
            end
            if (i < 5) begin
                i_x_cnt = xs[i]; i_y_cnt = ys[i]; i_pix_valid = pv[i];
            end else begin
                i_pix_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_tearing();
        logic [23:0] rgb; logic h, ov;
        i_x_pin = 10'd200;
        render_px(10'd100, 10'd53, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFF0000 || h !== 1'b1) begin
            bad++;
            $display("FAIL tear_hold: got rgb=%h hit=%b want rgb=ff0000 hit=1", rgb, h);
        end
        frame_pulse();
        render_px(10'd200, 10'd53, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFF0000 || h !== 1'b1) begin
            bad++;
            $display("FAIL tear_new: got rgb=%h hit=%b want rgb=ff0000 hit=1", rgb, h);
        end
        render_px(10'd100, 10'd53, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'h000000 || h !== 1'b0) begin
            bad++;
            $display("FAIL tear_old: got rgb=%h hit=%b want rgb=000000 hit=0", rgb, h);
        end
    endtask

    task automatic test_blink();
        logic        dark [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [23:0] rgb, exp_rgb; logic h, ov;
        set_card(10'd100, 10'd50, 4'd0, 2'b00, 2'b00, 1'b1);
        for (int f = 0; f < 5; f++) begin
            // Frame 2 checks a pixel entering on the frame_start cycle itself.
            if (f == 2) begin
                render_px(10'd100, 10'd70, 1'b1, 1'b1, rgb, h, ov);
            end else begin
                frame_pulse();
                render_px(10'd100, 10'd70, 1'b1, 1'b0, rgb, h, ov);
            end
            exp_rgb = dark[f] ? 24'h000000 : 24'hFF0000;
            total++;
            if (rgb !== exp_rgb || h !== 1'b1) begin
                bad++;
                $display("FAIL blink_border f=%0d: got rgb=%h hit=%b want rgb=%h hit=1", f, rgb, h, exp_rgb);
            end
            render_px(10'd105, 10'd55, 1'b1, 1'b0, rgb, h, ov);
            total++;
            if (rgb !== 24'hFFFFFF) begin
                bad++;
                $display("FAIL blink_interior f=%0d: got rgb=%h want rgb=ffffff", f, rgb);
            end
        end
        i_highlight = 1'b0;
        frame_pulse();
        frame_pulse();
        render_px(10'd100, 10'd70, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFF0000) begin
            bad++;
            $display("FAIL blink_off: got rgb=%h want rgb=ff0000", rgb);
        end
    endtask

    task automatic test_invalid_and_reset();
        logic [23:0] rgb; logic h, ov;
        render_px(10'd100, 10'd53, 1'b0, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'h0 || h !== 1'b0 || ov !== 1'b0) begin
            bad++;
            $display("FAIL invalid_px: got rgb=%h hit=%b vld=%b want 0/0/0", rgb, h, ov);
        end
        set_card(10'd200, 10'd50, 4'd0, 2'b00, 2'b00, 1'b0);
        frame_pulse();
        i_x_cnt = 10'd200; i_y_cnt = 10'd53; i_pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o_out_valid !== 1'b1 || {o_r_data, o_g_data, o_b_data} !== 24'hFF0000) begin
            bad++;
            $display("FAIL stream_pre_rst: got rgb=%h%h%h vld=%b want rgb=ff0000 vld=1",
                     o_r_data, o_g_data, o_b_data, o_out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (o_out_valid !== 1'b0 || o_hit !== 1'b0 || {o_r_data, o_g_data, o_b_data} !== 24'h0) begin
            bad++;
            $display("FAIL mid_rst: got rgb=%h%h%h hit=%b vld=%b want all 0",
                     o_r_data, o_g_data, o_b_data, o_hit, o_out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_valid: got vld=%b want 0", o_out_valid);
        end
        // Shadows cleared: card at (0,0), glyph 0, red, 1x until next frame_start.
        render_px(10'd0, 10'd3, 1'b1, 1'b0, rgb, h, ov);
        total++;
        if (rgb !== 24'hFF0000 || h !== 1'b1 || ov !== 1'b1) begin
            bad++;
            $display("FAIL shadow_rst: got rgb=%h hit=%b vld=%b want rgb=ff0000 hit=1 vld=1", rgb, h, ov);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_scale();
        test_colors();
        test_glyphs();
        test_back_to_back();
        test_tearing();
        test_blink();
        test_invalid_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
